cdb_arbiter: RTL and testbench

//  Shares NUM_CDB common-data-bus writeback ports among NUM_REQ functional-unit completions (add, mul, div, br).

---
 rtl/cdb_arbiter_if.sv | 35 +++
 rtl/cdb_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Bundle for cdb_arbiter: functional-unit completion requests in, CDB broadcast slots out.
// The arbiter uses the slave modport; the completion/broadcast side uses master.
interface cdb_arbiter_if #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned NUM_CDB   = 2,
    parameter int unsigned ROB_DEPTH = 64,
    parameter int unsigned DATA_W    = 32
);
    localparam int unsigned ROB_IDX_W = $clog2(ROB_DEPTH);
    localparam int unsigned PD_W      = 6;
    localparam int unsigned SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_ready;
    logic [NUM_REQ-1:0][ROB_IDX_W-1:0] req_rob_idx;
    logic [NUM_REQ-1:0][PD_W-1:0]      req_pd;
    logic [NUM_REQ-1:0][DATA_W-1:0]    req_data;
    logic                              flush;
    logic [ROB_IDX_W-1:0]              rob_head_idx;
    logic [NUM_CDB-1:0]                cdb_valid;
    logic [NUM_CDB-1:0][ROB_IDX_W-1:0] cdb_rob_idx;
    logic [NUM_CDB-1:0][PD_W-1:0]      cdb_pd;
    logic [NUM_CDB-1:0][DATA_W-1:0]    cdb_data;
    logic [NUM_CDB-1:0][SRC_W-1:0]     cdb_src;

    modport slave (
        input  req_valid, req_rob_idx, req_pd, req_data, flush, rob_head_idx,
        output req_ready, cdb_valid, cdb_rob_idx, cdb_pd, cdb_data, cdb_src
    );

    modport master (
        output req_valid, req_rob_idx, req_pd, req_data, flush, rob_head_idx,
        input  req_ready, cdb_valid, cdb_rob_idx, cdb_pd, cdb_data, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: one-entry holding buffer per functional unit, up to NUM_CDB buffered
// results granted per cycle onto registered CDB slots.
// Default ordering is round-robin from rr_ptr. Define CDB_AGE_PRIORITY_EN to order
// candidates by ROB age relative to rob_head_idx instead (oldest first, ties to lower index).
module cdb_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned NUM_CDB   = 2,
    parameter int unsigned ROB_DEPTH = 64,
    parameter int unsigned DATA_W    = 32
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.slave  bus
);
    localparam int unsigned ROB_IDX_W = $clog2(ROB_DEPTH);
    localparam int unsigned PD_W      = 6;
    localparam int unsigned SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Holding buffers
    logic [NUM_REQ-1:0]                buf_valid_q,   buf_valid_d;
    logic [NUM_REQ-1:0][ROB_IDX_W-1:0] buf_rob_idx_q, buf_rob_idx_d;
    logic [NUM_REQ-1:0][PD_W-1:0]      buf_pd_q,      buf_pd_d;
    logic [NUM_REQ-1:0][DATA_W-1:0]    buf_data_q,    buf_data_d;

    // Registered CDB slots
    logic [NUM_CDB-1:0]                cdb_valid_q,   cdb_valid_d;
    logic [NUM_CDB-1:0][ROB_IDX_W-1:0] cdb_rob_idx_q, cdb_rob_idx_d;
    logic [NUM_CDB-1:0][PD_W-1:0]      cdb_pd_q,      cdb_pd_d;
    logic [NUM_CDB-1:0][DATA_W-1:0]    cdb_data_q,    cdb_data_d;
    logic [NUM_CDB-1:0][SRC_W-1:0]     cdb_src_q,     cdb_src_d;

    // Arbitration results
    logic [NUM_REQ-1:0]                grant;
    logic [NUM_CDB-1:0]                slot_vld;
    logic [NUM_CDB-1:0][SRC_W-1:0]     slot_src;
    logic [NUM_REQ-1:0]                accept;

`ifdef CDB_AGE_PRIORITY_EN
    logic [NUM_REQ-1:0][ROB_IDX_W-1:0] age;
    logic                              found;
    logic [SRC_W-1:0]                  best;
    logic [ROB_IDX_W-1:0]              best_age;

    // Age of each buffered result relative to the ROB head (wraps modulo ROB_DEPTH)
    always_comb begin
        age = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            age[i] = buf_rob_idx_q[i] - bus.rob_head_idx;
        end
    end

    // Repeatedly pick the oldest ungranted valid buffer, one per slot
    always_comb begin
        grant    = '0;
        slot_vld = '0;
        slot_src = '0;
        found    = 1'b0;
        best     = '0;
        best_age = '0;
        for (int unsigned j = 0; j < NUM_CDB; j++) begin
            found    = 1'b0;
            best     = '0;
            best_age = '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (buf_valid_q[i] && !grant[i] && (!found || age[i] < best_age)) begin
                    found    = 1'b1;
                    best     = SRC_W'(i);
                    best_age = age[i];
                end
            end
            if (found) begin
                slot_vld[j] = 1'b1;
                slot_src[j] = best;
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (best == SRC_W'(i)) grant[i] = 1'b1;
                end
            end
        end
    end
`else
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0] last;
    int unsigned      cnt;
    int unsigned      idx;

    // Scan from rr_ptr with wraparound; the j-th valid buffer found goes to slot j
    always_comb begin
        grant    = '0;
        slot_vld = '0;
        slot_src = '0;
        last     = rr_ptr_q;
        cnt      = 0;
        idx      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (idx == i && buf_valid_q[i] && cnt < NUM_CDB) begin
                    grant[i] = 1'b1;
                    for (int unsigned j = 0; j < NUM_CDB; j++) begin
                        if (cnt == j) begin
                            slot_vld[j] = 1'b1;
                            slot_src[j] = SRC_W'(i);
                        end
                    end
                    last = SRC_W'(i);
                    cnt  = cnt + 1;
                end
            end
        end
    end

    // Pointer moves past the last winner; held on idle cycles and on flush
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (|grant && !bus.flush) begin
            rr_ptr_d = (last == SRC_W'(NUM_REQ - 1)) ? '0 : last + SRC_W'(1);
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end
`endif

    // A buffer accepts when empty or being drained this cycle; never during rst or flush
    assign bus.req_ready = (rst || bus.flush) ? '0 : (~buf_valid_q | grant);
    assign accept        = bus.req_valid & bus.req_ready;

    // Buffer next state: flush clears, accept loads (covers same-cycle refill), grant drains
    always_comb begin
        buf_valid_d   = buf_valid_q;
        buf_rob_idx_d = buf_rob_idx_q;
        buf_pd_d      = buf_pd_q;
        buf_data_d    = buf_data_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (bus.flush) begin
                buf_valid_d[i] = 1'b0;
            end else if (accept[i]) begin
                buf_valid_d[i]   = 1'b1;
                buf_rob_idx_d[i] = bus.req_rob_idx[i];
                buf_pd_d[i]      = bus.req_pd[i];
                buf_data_d[i]    = bus.req_data[i];
            end else if (grant[i]) begin
                buf_valid_d[i] = 1'b0;
            end
        end
    end

    // Slot payload mux from granted buffers; unused slots and flushed cycles carry zeros
    always_comb begin
        cdb_valid_d   = '0;
        cdb_rob_idx_d = '0;
        cdb_pd_d      = '0;
        cdb_data_d    = '0;
        cdb_src_d     = '0;
        if (!bus.flush) begin
            for (int unsigned j = 0; j < NUM_CDB; j++) begin
                cdb_valid_d[j] = slot_vld[j];
                cdb_src_d[j]   = slot_src[j];
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (slot_vld[j] && slot_src[j] == SRC_W'(i)) begin
                        cdb_rob_idx_d[j] = buf_rob_idx_q[i];
                        cdb_pd_d[j]      = buf_pd_q[i];
                        cdb_data_d[j]    = buf_data_q[i];
                    end
                end
            end
        end
    end

    // Buffer and CDB slot registers
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q   <= '0;
            buf_rob_idx_q <= '0;
            buf_pd_q      <= '0;
            buf_data_q    <= '0;
            cdb_valid_q   <= '0;
            cdb_rob_idx_q <= '0;
            cdb_pd_q      <= '0;
            cdb_data_q    <= '0;
            cdb_src_q     <= '0;
        end else begin
            buf_valid_q   <= buf_valid_d;
            buf_rob_idx_q <= buf_rob_idx_d;
            buf_pd_q      <= buf_pd_d;
            buf_data_q    <= buf_data_d;
            cdb_valid_q   <= cdb_valid_d;
            cdb_rob_idx_q <= cdb_rob_idx_d;
            cdb_pd_q      <= cdb_pd_d;
            cdb_data_q    <= cdb_data_d;
            cdb_src_q     <= cdb_src_d;
        end
    end

    assign bus.cdb_valid   = cdb_valid_q;
    assign bus.cdb_rob_idx = cdb_rob_idx_q;
    assign bus.cdb_pd      = cdb_pd_q;
    assign bus.cdb_data    = cdb_data_q;
    assign bus.cdb_src     = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single result, refill, round-robin contention,
// flush, and the rob_head_idx=60 ordering scenario (expectations follow CDB_AGE_PRIORITY_EN).
module tb_cdb_arbiter;
    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    cdb_arbiter_if #(.NUM_REQ(4), .NUM_CDB(2), .ROB_DEPTH(64), .DATA_W(32)) bus ();

    cdb_arbiter #(.NUM_REQ(4), .NUM_CDB(2), .ROB_DEPTH(64), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next active edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [5:0] idx, input logic [5:0] pd, input logic [31:0] data);
        bus.req_valid[i]   = 1'b1;
        bus.req_rob_idx[i] = idx;
        bus.req_pd[i]      = pd;
        bus.req_data[i]    = data;
    endtask

    task automatic check_slot(input string tag, input int k, input logic [1:0] src, input logic [5:0] idx);
        check({tag, "_src"}, 64'(bus.cdb_src[k]), 64'(src));
        check({tag, "_idx"}, 64'(bus.cdb_rob_idx[k]), 64'(idx));
    endtask

    initial begin
        rst              = 1'b1;
        bus.flush        = 1'b0;
        bus.rob_head_idx = '0;
        bus.req_valid    = 4'hF;
        bus.req_rob_idx  = '0;
        bus.req_pd       = '0;
        bus.req_data     = '0;

        // Reset with all requests asserted
        step();
        check("rst_ready0", 64'(bus.req_ready), 64'h0);
        check("rst_valid0", 64'(bus.cdb_valid), 64'h0);
        step();
        check("rst_ready1", 64'(bus.req_ready), 64'h0);
        check("rst_valid1", 64'(bus.cdb_valid), 64'h0);
        rst           = 1'b0;
        bus.req_valid = '0;
        step();
        check("post_rst_valid", 64'(bus.cdb_valid), 64'h0);
        check("post_rst_ready", 64'(bus.req_ready), 64'hF);
        step();
        check("post_rst_valid2", 64'(bus.cdb_valid), 64'h0);

        // Single result, two-cycle latency
        drive(0, 6'd5, 6'd12, 32'hDEADBEEF);
        step();
        bus.req_valid = '0;
        check("single_lat1", 64'(bus.cdb_valid), 64'h0);
        step();
        check("single_valid", 64'(bus.cdb_valid), 64'h1);
        check("single_idx", 64'(bus.cdb_rob_idx[0]), 64'd5);
        check("single_pd", 64'(bus.cdb_pd[0]), 64'd12);
        check("single_data", 64'(bus.cdb_data[0]), 64'hDEADBEEF);
        check("single_src", 64'(bus.cdb_src[0]), 64'd0);
        step();
        check("single_done", 64'(bus.cdb_valid), 64'h0);

        // Unit 1 streams four results back-to-back through its refilling buffer
        for (int c = 0; c < 4; c++) begin
            drive(1, 6'(10 + c), 6'd7, 32'h1000 + 32'(c));
            #1;
            check("refill_ready", 64'(bus.req_ready[1]), 64'h1);
            if (c >= 2) begin
                check("refill_valid", 64'(bus.cdb_valid), 64'h1);
                check_slot("refill", 0, 2'd1, 6'(10 + c - 2));
            end
            step();
        end
        bus.req_valid = '0;
        check("refill_valid2", 64'(bus.cdb_valid), 64'h1);
        check("refill_data2", 64'(bus.cdb_data[0]), 64'h1002);
        step();
        check("refill_valid3", 64'(bus.cdb_valid), 64'h1);
        check_slot("refill3", 0, 2'd1, 6'd13);
        step();
        check("refill_done", 64'(bus.cdb_valid), 64'h0);

        // Lone unit 3 result
        drive(3, 6'd20, 6'd33, 32'hCAFE);
        step();
        bus.req_valid = '0;
        step();
        check("u3_valid", 64'(bus.cdb_valid), 64'h1);
        check_slot("u3", 0, 2'd3, 6'd20);
        step();

        // Full contention starting from pointer 0
        for (int i = 0; i < 4; i++) drive(i, 6'(30 + i), 6'(i + 1), 32'hA0 + 32'(i));
        step();
        bus.req_valid = '0;
        #1;
        check("cont_ready", 64'(bus.req_ready), 64'h3);
        step();
        check("cont_valid_a", 64'(bus.cdb_valid), 64'h3);
        check_slot("cont_a0", 0, 2'd0, 6'd30);
        check_slot("cont_a1", 1, 2'd1, 6'd31);
        check("cont_pd_a1", 64'(bus.cdb_pd[1]), 64'd2);
        step();
        check("cont_valid_b", 64'(bus.cdb_valid), 64'h3);
        check_slot("cont_b0", 0, 2'd2, 6'd32);
        check_slot("cont_b1", 1, 2'd3, 6'd33);
        check("cont_data_b1", 64'(bus.cdb_data[1]), 64'hA3);
        step();
        check("cont_done", 64'(bus.cdb_valid), 64'h0);

        // Flush with three buffers full and a request presented during flush
        for (int i = 0; i < 3; i++) drive(i, 6'(40 + i), 6'd1, 32'h55);
        step();
        bus.req_valid = '0;
        bus.flush     = 1'b1;
        drive(3, 6'd43, 6'd2, 32'h66);
        #1;
        check("flush_ready", 64'(bus.req_ready), 64'h0);
        step();
        bus.flush     = 1'b0;
        bus.req_valid = '0;
        check("flush_valid0", 64'(bus.cdb_valid), 64'h0);
        #1;
        check("flush_empty", 64'(bus.req_ready), 64'hF);
        step();
        check("flush_valid1", 64'(bus.cdb_valid), 64'h0);
        step();
        check("flush_valid2", 64'(bus.cdb_valid), 64'h0);

        // Ordering with rob_head_idx=60 and buffered idx {62, 1, 61, 3}
        bus.rob_head_idx = 6'd60;
        drive(0, 6'd62, 6'd3, 32'h0);
        drive(1, 6'd1,  6'd3, 32'h1);
        drive(2, 6'd61, 6'd3, 32'h2);
        drive(3, 6'd3,  6'd3, 32'h3);
        step();
        bus.req_valid = '0;
        step();
        check("ord_valid_a", 64'(bus.cdb_valid), 64'h3);
`ifdef CDB_AGE_PRIORITY_EN
        check_slot("age_a0", 0, 2'd2, 6'd61);
        check_slot("age_a1", 1, 2'd0, 6'd62);
`else
        check_slot("rr_a0", 0, 2'd0, 6'd62);
        check_slot("rr_a1", 1, 2'd1, 6'd1);
`endif
        step();
        check("ord_valid_b", 64'(bus.cdb_valid), 64'h3);
`ifdef CDB_AGE_PRIORITY_EN
        check_slot("age_b0", 0, 2'd1, 6'd1);
        check_slot("age_b1", 1, 2'd3, 6'd3);
`else
        check_slot("rr_b0", 0, 2'd2, 6'd61);
        check_slot("rr_b1", 1, 2'd3, 6'd3);
`endif
        step();
        check("ord_done", 64'(bus.cdb_valid), 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
